// File: rtl/reg_file_param.sv
// Parametrised register file: NUM_RD combinational read ports, one write port and a
// valid/ready debug snapshot stream. Optional same-cycle write bypass: WRITE_BYPASS_EN.
module reg_file_param #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       dbg_start,
    output logic                       dbg_busy,
    output logic                       dbg_valid,
    input  logic                       dbg_ready,
    output logic [ADDR_W-1:0]          dbg_idx,
    output logic [DATA_W-1:0]          dbg_data,
    output logic                       dbg_last
);

    localparam bit                ZERO_EN  = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_live;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // A write to the hardwired zero register is dropped entirely.
    assign wr_live = wr_en && !(ZERO_EN && (wr_addr == '0));

    // Storage array
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Independent combinational read ports
    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            val = regs_q[addr];
            if (ZERO_EN && (addr == '0)) begin
                val = '0;
            end
`ifdef WRITE_BYPASS_EN
            if (wr_live && (addr == wr_addr)) begin
                val = wr_data;
            end
`endif
        end

        assign rd_data[p*DATA_W +: DATA_W] = val;
    end

    // Snapshot FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Snapshot next-state; dbg_start is ignored once a scan is running
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (dbg_start) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                if (dbg_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Snapshot outputs decode directly from the state registers
    always_comb begin
        dbg_valid = (state_q == ST_SCAN);
        dbg_busy  = (state_q == ST_SCAN);
        dbg_idx   = idx_q;
        dbg_last  = (state_q == ST_SCAN) && (idx_q == LAST_IDX);
    end

    // Live snapshot data, so writes to not-yet-presented registers are streamed
    always_comb begin
        dbg_data = regs_q[idx_q];
        if (ZERO_EN && (idx_q == '0)) begin
            dbg_data = '0;
        end
`ifdef WRITE_BYPASS_EN
        if (wr_live && (idx_q == wr_addr)) begin
            dbg_data = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: directed table, hand-written scan sequences
// and randomized traffic compared against an array/flag model of the register file.
module tb_reg_file_param;

    localparam int unsigned DW = 64;
    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;

`ifdef WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic            dbg_start, dbg_busy, dbg_valid, dbg_ready, dbg_last;
    logic [AW-1:0]   dbg_idx;
    logic [DW-1:0]   dbg_data;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: plain array plus scan progress
    logic [DW-1:0] mdl [NR];
    bit            scanning;
    int            exp_idx;

    reg_file_param #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .dbg_start(dbg_start), .dbg_busy(dbg_busy),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_idx(dbg_idx),
        .dbg_data(dbg_data), .dbg_last(dbg_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input int a);
        if (a == 0) return '0;
        if (BYP && wr_en && (int'(wr_addr) == a)) return wr_data;
        return mdl[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NR); i++) mdl[i] = '0;
        scanning = 1'b0;
        exp_idx  = 0;
    endtask

    task automatic model_check();
        chk("rd0", rd_data[DW-1:0], exp_read(int'(rd_addr[AW-1:0])));
        chk("rd1", rd_data[2*DW-1:DW], exp_read(int'(rd_addr[2*AW-1:AW])));
        chk("dbg_valid", 64'(dbg_valid), 64'(scanning));
        chk("dbg_busy", 64'(dbg_busy), 64'(scanning));
        chk("dbg_idx", 64'(dbg_idx), 64'(exp_idx));
        chk("dbg_last", 64'(dbg_last), 64'(scanning && exp_idx == int'(NR) - 1));
        chk("dbg_data", dbg_data, exp_read(exp_idx));
    endtask

    // Advance the model to the state after the coming rising edge
    task automatic model_update();
        if (wr_en && wr_addr != '0) mdl[wr_addr] = wr_data;
        if (scanning) begin
            if (dbg_ready) begin
                if (exp_idx == int'(NR) - 1) begin
                    scanning = 1'b0;
                    exp_idx  = 0;
                end else begin
                    exp_idx++;
                end
            end
        end else if (dbg_start) begin
            scanning = 1'b1;
            exp_idx  = 0;
        end
    endtask

    // One clock cycle: drive at negedge, check 1ns later, update model; returns before posedge
    task automatic cycle(input bit we, input int wa, input logic [DW-1:0] wd,
                         input int ra0, input int ra1, input bit st, input bit rdy);
        @(negedge clk);
        wr_en     = we;
        wr_addr   = AW'(wa);
        wr_data   = wd;
        rd_addr   = {AW'(ra1), AW'(ra0)};
        dbg_start = st;
        dbg_ready = rdy;
        #1;
        model_check();
        model_update();
    endtask

    typedef struct {
        bit            we;
        int            wa;
        logic [DW-1:0] wd;
        int            ra0;
        int            ra1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    vec_t tbl[9];

    localparam logic [DW-1:0] V5  = 64'h1234_5678_9ABC_DEF0;
    localparam logic [DW-1:0] V31 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [AW-1:0]  bidx_q[$];
        logic [DW-1:0]  bdat_q[$];
        bit             wrote;
        int             n;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        dbg_start = 1'b0; dbg_ready = 1'b0;
        model_reset();
        @(negedge clk); #1;
        chk("init_rd0", rd_data[DW-1:0], 64'd0);
        chk("init_valid", 64'(dbg_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: asynchronous reset clears pre-written registers without a clock edge
        cycle(1, 1, 64'hDEAD, 0, 0, 0, 0);
        cycle(1, 2, 64'hDEAD, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 2, 0, 0);
        chk("t1_pre_x2", rd_data[2*DW-1:DW], 64'hDEAD);
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("t1_rst_rd0", rd_data[DW-1:0], 64'd0);
        chk("t1_rst_rd1", rd_data[2*DW-1:DW], 64'd0);
        chk("t1_rst_valid", 64'(dbg_valid), 64'd0);
        chk("t1_rst_idx", 64'(dbg_idx), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Tests 2/3: directed table (expected values are this cycle's combinational reads)
        tbl[0] = '{1'b1, 5,  V5,     0, 0, 64'd0, 64'd0};
        tbl[1] = '{1'b1, 31, V31,    5, 31, V5, BYP ? V31 : 64'd0};
        tbl[2] = '{1'b1, 0,  64'h55, 5, 31, V5, V31};
        tbl[3] = '{1'b0, 0,  64'd0,  0, 31, 64'd0, V31};
        tbl[4] = '{1'b1, 7,  64'h11, 0, 5, 64'd0, V5};
        tbl[5] = '{1'b1, 7,  64'hAA, 7, 0, BYP ? 64'hAA : 64'h11, 64'd0};
        tbl[6] = '{1'b0, 0,  64'd0,  7, 7, 64'hAA, 64'hAA};
        tbl[7] = '{1'b1, 0,  64'h77, 0, 0, 64'd0, 64'd0};
        tbl[8] = '{1'b0, 0,  64'd0,  0, 7, 64'd0, 64'hAA};
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra0, tbl[i].ra1, 0, 0);
            chk($sformatf("tbl%0d_rd0", i), rd_data[DW-1:0], tbl[i].e0);
            chk($sformatf("tbl%0d_rd1", i), rd_data[2*DW-1:DW], tbl[i].e1);
        end

        // Test 4: full scan with ready held high
        for (int i = 0; i < int'(NR); i++) cycle(1, i, 64'(i * 3), 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        chk("t4_start_valid", 64'(dbg_valid), 64'd0);
        for (int k = 0; k < int'(NR); k++) begin
            cycle(0, 0, 0, 0, 0, 0, 1);
            chk("t4_valid", 64'(dbg_valid), 64'd1);
            chk("t4_idx", 64'(dbg_idx), 64'(k));
            chk("t4_data", dbg_data, 64'(k * 3));
            chk("t4_last", 64'(dbg_last), 64'(k == int'(NR) - 1));
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("t4_busy_after", 64'(dbg_busy), 64'd0);

        // Test 5: ready 1 high / 2 low, write 0x99 to x20 while idx 10 is presented
        cycle(0, 0, 0, 0, 0, 1, 0);
        wrote = 1'b0;
        n = 0;
        while ((scanning || bidx_q.size() == 0) && n < 200) begin
            bit rdy;
            bit we;
            rdy = (n % 3 == 0);
            we  = !wrote && scanning && exp_idx == 10;
            if (we) wrote = 1'b1;
            cycle(we, 20, 64'h99, 0, 20, 0, rdy);
            if (dbg_valid && rdy) begin
                bidx_q.push_back(dbg_idx);
                bdat_q.push_back(dbg_data);
            end
            n++;
        end
        chk("t5_beats", 64'(bidx_q.size()), 64'(NR));
        chk("t5_wrote", 64'(wrote), 64'd1);
        for (int k = 0; k < bidx_q.size(); k++) begin
            chk("t5_idx", 64'(bidx_q[k]), 64'(k));
            chk("t5_data", bdat_q[k], (k == 20) ? 64'h99 : 64'(k * 3));
        end

        // Test 6: reset mid-scan at idx 12
        cycle(0, 0, 0, 0, 0, 1, 0);
        n = 0;
        while (!(scanning && exp_idx == 12) && n < 50) begin
            cycle(0, 0, 0, 0, 0, 0, 1);
            n++;
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("t6_idx12", 64'(dbg_idx), 64'd12);
        reset = 1'b1;
        #1;
        model_reset();
        chk("t6_valid", 64'(dbg_valid), 64'd0);
        chk("t6_busy", 64'(dbg_busy), 64'd0);
        chk("t6_idx", 64'(dbg_idx), 64'd0);
        chk("t6_last", 64'(dbg_last), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("t6_restart_valid", 64'(dbg_valid), 64'd1);
        chk("t6_restart_idx", 64'(dbg_idx), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int wa;
            int ra0;
            wa  = int'($urandom_range(0, NR - 1));
            ra0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NR - 1));
            cycle($urandom_range(0, 1) == 1, wa, {$urandom, $urandom}, ra0,
                  int'($urandom_range(0, NR - 1)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
